// File: rtl/fetch_queue_pkg.sv
// Shared types and defaults for the z86 instruction prefetch queue.
package fetch_queue_pkg;

  localparam int unsigned FETCH_QUEUE_DEPTH = 6;
  localparam int unsigned WIN_BYTES         = 4;
  localparam logic [15:0] DEFAULT_RESET_CS  = 16'hFFFF;
  localparam logic [15:0] DEFAULT_RESET_IP  = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Real-mode linear address: CS*16 + IP, wrapping at 1 MiB.
  function automatic logic [19:0] fetch_linear_addr(input logic [15:0] cs,
                                                    input logic [15:0] ip);
    return {cs, 4'b0000} + {4'b0000, ip};
  endfunction

endpackage

// File: rtl/fetch_byte_fifo.sv
// Circular byte store for the prefetch queue: 0-2 byte writes, 4-byte head
// window, 0-4 byte pops, synchronous clear. Pointers wrap modulo DEPTH.
module fetch_byte_fifo
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [1:0]       wr_n_i,
  input  logic [15:0]      wr_data_i,
  input  logic [2:0]       pop_n_i,
  output logic [31:0]      win_c_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Modulo-DEPTH pointer advance; n never exceeds DEPTH so one fold suffices.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p,
                                                input logic [2:0]       n);
    int unsigned s;
    s = int'(p) + int'(n);
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  // Next pointer and occupancy values.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (clr_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      rd_d    = wrap_add(rd_q, pop_n_i);
      wr_d    = wrap_add(wr_q, {1'b0, wr_n_i});
      count_d = count_q - CNT_W'(pop_n_i) + CNT_W'(wr_n_i);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Byte storage; contents beyond count are never observed, so no reset.
  always_ff @(posedge clk) begin
    if (!clr_i) begin
      if (wr_n_i != 2'd0) mem_q[wr_q] <= wr_data_i[7:0];
      if (wr_n_i == 2'd2) mem_q[wrap_add(wr_q, 3'd1)] <= wr_data_i[15:8];
    end
  end

  // Head window, zero-filled past the valid bytes.
  always_comb begin
    win_c_o = '0;
    for (int i = 0; i < int'(WIN_BYTES); i++) begin
      if (i < int'(count_q)) win_c_o[i*8 +: 8] = mem_q[wrap_add(rd_q, 3'(i))];
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// z86 instruction prefetch queue: fetch FSM, CS:IP tracking, BIU handshake.
// Build option Z86_FETCH_BYPASS_EN forwards arriving bytes to the decode
// window in the same cycle when the queue is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = FETCH_QUEUE_DEPTH,
  parameter logic [15:0] RESET_CS    = DEFAULT_RESET_CS,
  parameter logic [15:0] RESET_IP    = DEFAULT_RESET_IP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_taken,
  input  logic [15:0] br_new_cs,
  input  logic [15:0] br_new_ip,
  output logic        mem_req,
  output logic [19:0] mem_addr,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic [31:0] q_data,
  output logic [2:0]  q_avail,
  output logic [15:0] q_ip,
  input  logic        consume,
  input  logic [2:0]  consume_n
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

  fetch_state_t     state_q, state_d;
  logic [15:0]      fetch_cs_q, fetch_cs_d;
  logic [15:0]      fetch_ip_q, fetch_ip_d;
  logic [15:0]      q_ip_q, q_ip_d;
  logic             mem_req_q, mem_req_d;
  logic [19:0]      mem_addr_q, mem_addr_d;

  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      fifo_win;
  logic [2:0]       fifo_avail_c;
  logic [1:0]       fsz_c;
  logic [15:0]      fill_data_c;
  logic             fill_valid_c;
  logic [2:0]       pop_c;
  logic [1:0]       fifo_wr_n_c;
  logic [15:0]      fifo_wr_data_c;
  logic [2:0]       fifo_pop_c;
  logic             free_ok_c;

  // Fetch size and byte ordering of the word on the bus.
  always_comb begin
    fsz_c        = fetch_ip_q[0] ? 2'd1 : 2'd2;
    fill_data_c  = fetch_ip_q[0] ? {8'h00, mem_rdata[15:8]} : mem_rdata;
    fill_valid_c = (state_q == REQ) && mem_ready && !br_taken;
    fifo_avail_c = (fifo_count >= CNT_W'(4)) ? 3'd4 : 3'(fifo_count);
  end

`ifdef Z86_FETCH_BYPASS_EN
  logic bypass_c;

  // Decode window with same-cycle forwarding into an empty queue.
  always_comb begin
    bypass_c = fill_valid_c && (fifo_count == '0);
    q_avail  = bypass_c ? {1'b0, fsz_c} : fifo_avail_c;
    q_data   = bypass_c ? {16'h0000, fill_data_c} : fifo_win;
    pop_c    = '0;
    if (consume) pop_c = (consume_n > q_avail) ? q_avail : consume_n;
    fifo_pop_c     = pop_c;
    fifo_wr_n_c    = fill_valid_c ? fsz_c : 2'd0;
    fifo_wr_data_c = fill_data_c;
    if (bypass_c) begin
      fifo_pop_c     = '0;
      fifo_wr_n_c    = fsz_c - 2'(pop_c);
      fifo_wr_data_c = (pop_c == 3'd1) ? {8'h00, fill_data_c[15:8]} : fill_data_c;
    end
    if (br_taken) begin
      fifo_pop_c  = '0;
      fifo_wr_n_c = 2'd0;
    end
  end
`else
  // Decode window straight from the byte store.
  always_comb begin
    q_avail = fifo_avail_c;
    q_data  = fifo_win;
    pop_c   = '0;
    if (consume) pop_c = (consume_n > q_avail) ? q_avail : consume_n;
    fifo_pop_c     = br_taken ? 3'd0 : pop_c;
    fifo_wr_n_c    = fill_valid_c ? fsz_c : 2'd0;
    fifo_wr_data_c = fill_data_c;
  end
`endif

  // Space check for a new request, counting this cycle's consume.
  always_comb begin
    free_ok_c = (int'(QUEUE_DEPTH) - int'(fifo_count) + int'(fifo_pop_c)) >= int'(fsz_c);
  end

  fetch_byte_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .clr_i     (br_taken),
    .wr_n_i    (fifo_wr_n_c),
    .wr_data_i (fifo_wr_data_c),
    .pop_n_i   (fifo_pop_c),
    .win_c_o   (fifo_win),
    .count_o   (fifo_count)
  );

  // Fetch FSM next state, bus outputs and CS:IP bookkeeping.
  always_comb begin
    state_d    = state_q;
    fetch_cs_d = fetch_cs_q;
    fetch_ip_d = fetch_ip_q;
    q_ip_d     = q_ip_q + 16'(pop_c);
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;

    case (state_q)
      IDLE: begin
        if (!br_taken && free_ok_c) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_linear_addr(fetch_cs_q, fetch_ip_q);
        end
      end
      REQ: begin
        if (br_taken) begin
          if (mem_ready) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end else begin
            state_d = DRAIN;
          end
        end else if (mem_ready) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          fetch_ip_d = fetch_ip_q + 16'(fsz_c);
        end
      end
      DRAIN: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    if (br_taken) begin
      fetch_cs_d = br_new_cs;
      fetch_ip_d = br_new_ip;
      q_ip_d     = br_new_ip;
    end
  end

  // State and bus registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_cs_q <= RESET_CS;
      fetch_ip_q <= RESET_IP;
      q_ip_q     <= RESET_IP;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_cs_q <= fetch_cs_d;
      fetch_ip_q <= fetch_ip_d;
      q_ip_q     <= q_ip_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign q_ip     = q_ip_q;

  // Decoder must never take more bytes than are offered (empty window is a no-op).
  a_consume_le_avail : assert property (@(posedge clk) disable iff (reset)
    (consume && (q_avail != 3'd0)) |-> (consume_n <= q_avail));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (default build).
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_new_cs = '0;
  logic [15:0] br_new_ip = '0;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [31:0] q_data;
  logic [2:0]  q_avail;
  logic [15:0] q_ip;
  logic        consume = 1'b0;
  logic [2:0]  consume_n = '0;

  int total = 0;
  int bad   = 0;

  fetch_queue dut (
    .clk       (clk),
    .reset     (reset),
    .br_taken  (br_taken),
    .br_new_cs (br_new_cs),
    .br_new_ip (br_new_ip),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .q_data    (q_data),
    .q_avail   (q_avail),
    .q_ip      (q_ip),
    .consume   (consume),
    .consume_n (consume_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a request, check its address, answer with one ready cycle.
  task automatic fetch_word(input logic [19:0] a, input logic [15:0] d, input string tag);
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, 32'(mem_req), 32'h1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
    mem_ready = 1'b1;
    mem_rdata = d;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req",   32'(mem_req),  32'h0);
    chk("rst_addr",  32'(mem_addr), 32'h0);
    chk("rst_data",  q_data,        32'h0);
    chk("rst_avail", 32'(q_avail),  32'h0);
    chk("rst_ip",    32'(q_ip),     32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Fill from FFFF:0000 until full
    fetch_word(20'hFFFF0, 16'h1100, "f0");
    chk("f0_avail", 32'(q_avail), 32'h2);
    chk("f0_data",  q_data,       32'h0000_1100);
    fetch_word(20'hFFFF2, 16'h3322, "f1");
    fetch_word(20'hFFFF4, 16'h5544, "f2");
    chk("full_avail", 32'(q_avail), 32'h4);
    chk("full_data",  q_data,       32'h3322_1100);
    chk("full_ip",    32'(q_ip),    32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_noreq", 32'(mem_req), 32'h0);
    end

    // Consume 2 frees room: request issues the same cycle
    consume = 1'b1; consume_n = 3'd2;
    @(negedge clk);
    consume = 1'b0;
    chk("c2_avail", 32'(q_avail),  32'h4);
    chk("c2_data",  q_data,        32'h5544_3322);
    chk("c2_ip",    32'(q_ip),     32'h2);
    chk("c2_req",   32'(mem_req),  32'h1);
    chk("c2_addr",  32'(mem_addr), 32'hFFFF6);

    // Consume 3 with same-cycle fill; read pointer wraps 5 -> 0
    consume = 1'b1; consume_n = 3'd3;
    mem_ready = 1'b1; mem_rdata = 16'h7766;
    @(negedge clk);
    consume = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    chk("wrap_avail", 32'(q_avail), 32'h3);
    chk("wrap_data",  q_data,       32'h0077_6655);
    chk("wrap_ip",    32'(q_ip),    32'h5);
    chk("wrap_req",   32'(mem_req), 32'h0);
    fetch_word(20'hFFFF8, 16'h9988, "f3");
    chk("f3_data",  q_data,       32'h8877_6655);
    chk("f3_avail", 32'(q_avail), 32'h4);
    @(negedge clk);
    chk("five_noreq", 32'(mem_req), 32'h0);

    // Redirect to 1000:0003; consume on the empty window is a no-op
    br_taken = 1'b1; br_new_cs = 16'h1000; br_new_ip = 16'h0003;
    @(negedge clk);
    br_taken = 1'b0;
    chk("br_avail", 32'(q_avail), 32'h0);
    chk("br_ip",    32'(q_ip),    32'h3);
    chk("br_req",   32'(mem_req), 32'h0);
    consume = 1'b1; consume_n = 3'd2;
    @(negedge clk);
    consume = 1'b0;
    chk("noop_ip",   32'(q_ip),    32'h3);
    chk("noop_avail", 32'(q_avail), 32'h0);
    fetch_word(20'h10003, 16'hABCD, "odd");
    chk("odd_avail", 32'(q_avail), 32'h1);
    chk("odd_data",  q_data,       32'h0000_00AB);
    fetch_word(20'h10004, 16'h2211, "even");
    chk("even_avail", 32'(q_avail), 32'h3);
    chk("even_data",  q_data,       32'h0022_11AB);

    // Redirect while a request is pending: drain the old fetch
    for (int i = 0; i < 10 && mem_req !== 1'b1; i++) @(negedge clk);
    chk("pend_addr", 32'(mem_addr), 32'h10006);
    br_taken = 1'b1; br_new_cs = 16'h2000; br_new_ip = 16'hFFFE;
    @(negedge clk);
    br_taken = 1'b0;
    chk("drain_req",   32'(mem_req),  32'h1);
    chk("drain_addr",  32'(mem_addr), 32'h10006);
    chk("drain_avail", 32'(q_avail),  32'h0);
    chk("drain_ip",    32'(q_ip),     32'hFFFE);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("drain_hold_req",   32'(mem_req), 32'h1);
      chk("drain_hold_avail", 32'(q_avail), 32'h0);
    end
    mem_ready = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = '0;
    chk("drained_avail", 32'(q_avail), 32'h0);
    chk("drained_req",   32'(mem_req), 32'h0);

    // Fetch IP wraps within the segment
    fetch_word(20'h2FFFE, 16'h3412, "segend");
    chk("segend_data", q_data, 32'h0000_3412);
    fetch_word(20'h20000, 16'h5645, "segwrap");
    chk("segwrap_avail", 32'(q_avail), 32'h4);
    chk("segwrap_data",  q_data,       32'h5645_3412);
    chk("segwrap_ip",    32'(q_ip),    32'hFFFE);
    consume = 1'b1; consume_n = 3'd2;
    @(negedge clk);
    consume = 1'b0;
    chk("ipwrap_ip",    32'(q_ip),     32'h0);
    chk("ipwrap_avail", 32'(q_avail),  32'h2);
    chk("ipwrap_data",  q_data,        32'h0000_5645);
    chk("ipwrap_req",   32'(mem_req),  32'h1);
    chk("ipwrap_addr",  32'(mem_addr), 32'h20002);

    // Reset in the middle of a request
    reset = 1'b1;
    #1;
    chk("mrst_req",   32'(mem_req),  32'h0);
    chk("mrst_addr",  32'(mem_addr), 32'h0);
    chk("mrst_data",  q_data,        32'h0);
    chk("mrst_avail", 32'(q_avail),  32'h0);
    chk("mrst_ip",    32'(q_ip),     32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_req",  32'(mem_req),  32'h1);
    chk("post_addr", 32'(mem_addr), 32'hFFFF0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
